// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pipe_pkg
// Shared pipeline defines for the EX/MEM boundary: the reset level, the NOP
// encodings used when a bubble or a flush is inserted, the positions of the
// EX/MEM bits in the stall vector and the default opcode width.
package ex_mem_pipe_pkg;

    localparam logic        RST_ENABLE   = 1'b1;
    localparam int unsigned NOP_REG_ADDR = 0;
    localparam int unsigned ZERO_WORD    = 0;
    localparam int unsigned EXE_NOP_OP   = 0;

    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;

    localparam int unsigned OP_W_DEF = 8;

endpackage

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe
// EX -> MEM pipeline register. Carries the GPR writeback, HI/LO writeback and
// load/store information forward one cycle, and returns the multi-cycle
// (madd/msub) intermediate result and step count back to EX while EX is
// stalled, so a multi-cycle operation can resume on the next pass.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall[5:0]          stall vector; bit 3 = EX stall, bit 4 = MEM stall
//   flush               exception flush, clears the stage
//   ex_*                values produced by EX this cycle
//   hilo_i, cnt_i       multi-cycle intermediate result / step count from EX
//   mem_*               registered copies of ex_* presented to MEM
//   hilo_o, cnt_o       intermediate result / step count returned to EX
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = OP_W_DEF,
    parameter int CNT_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,

    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [OP_W-1:0]     ex_aluop,
    input  logic [DATA_W-1:0]   ex_mem_addr,
    input  logic [DATA_W-1:0]   ex_reg2,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [CNT_W-1:0]    cnt_i,

    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [OP_W-1:0]     mem_aluop,
    output logic [DATA_W-1:0]   mem_mem_addr,
    output logic [DATA_W-1:0]   mem_reg2,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [CNT_W-1:0]    cnt_o
);

    logic ex_stall;
    logic mem_stall;

    assign ex_stall  = stall[STALL_EX];
    assign mem_stall = stall[STALL_MEM];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || flush) begin
            // Reset and flush both drop the stage to NOP and abandon any
            // multi-cycle operation in progress.
            mem_wd       <= ADDR_W'(NOP_REG_ADDR);
            mem_wreg     <= 1'b0;
            mem_wdata    <= DATA_W'(ZERO_WORD);
            mem_hi       <= DATA_W'(ZERO_WORD);
            mem_lo       <= DATA_W'(ZERO_WORD);
            mem_whilo    <= 1'b0;
            mem_aluop    <= OP_W'(EXE_NOP_OP);
            mem_mem_addr <= DATA_W'(ZERO_WORD);
            mem_reg2     <= DATA_W'(ZERO_WORD);
            hilo_o       <= '0;
            cnt_o        <= '0;
        end else if (mem_stall) begin
            // MEM stalled: hold everything. This also covers the illegal
            // combination of MEM stalled with EX running, where capturing a
            // new instruction would overwrite one MEM has not consumed.
        end else if (ex_stall) begin
            // EX stalled, MEM running: insert a bubble, and loop the
            // multi-cycle state back to EX so it can continue next cycle.
            mem_wd       <= ADDR_W'(NOP_REG_ADDR);
            mem_wreg     <= 1'b0;
            mem_wdata    <= DATA_W'(ZERO_WORD);
            mem_hi       <= DATA_W'(ZERO_WORD);
            mem_lo       <= DATA_W'(ZERO_WORD);
            mem_whilo    <= 1'b0;
            mem_aluop    <= OP_W'(EXE_NOP_OP);
            mem_mem_addr <= DATA_W'(ZERO_WORD);
            mem_reg2     <= DATA_W'(ZERO_WORD);
            hilo_o       <= hilo_i;
            cnt_o        <= cnt_i;
        end else begin
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_whilo    <= ex_whilo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
            hilo_o       <= '0;
            cnt_o        <= '0;
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe
// Directed plus short random sequence for ex_mem_pipe. Each driven cycle
// pushes the expected stage contents onto a scoreboard queue; after the edge
// the entry is popped and compared field by field against the DUT.
module tb_ex_mem_pipe;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } st_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    st_t         in;     // ex_* inputs, hilo_i, cnt_i
    st_t         dut;
    st_t         model;
    st_t         sb[$];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ex_mem_pipe dut_i (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .ex_wd       (in.wd),
        .ex_wreg     (in.wreg),
        .ex_wdata    (in.wdata),
        .ex_hi       (in.hi),
        .ex_lo       (in.lo),
        .ex_whilo    (in.whilo),
        .ex_aluop    (in.aluop),
        .ex_mem_addr (in.addr),
        .ex_reg2     (in.reg2),
        .hilo_i      (in.hilo),
        .cnt_i       (in.cnt),
        .mem_wd      (dut.wd),
        .mem_wreg    (dut.wreg),
        .mem_wdata   (dut.wdata),
        .mem_hi      (dut.hi),
        .mem_lo      (dut.lo),
        .mem_whilo   (dut.whilo),
        .mem_aluop   (dut.aluop),
        .mem_mem_addr(dut.addr),
        .mem_reg2    (dut.reg2),
        .hilo_o      (dut.hilo),
        .cnt_o       (dut.cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Reference behaviour of one edge: rst > flush > MEM stall (hold) >
    // EX stall (bubble) > normal.
    function automatic st_t next_state(st_t cur, st_t x, logic r, logic f, logic [5:0] s);
        st_t n;
        n = '0;
        if (r || f)       n = '0;
        else if (s[4])    n = cur;
        else if (s[3]) begin
            n.hilo = x.hilo;
            n.cnt  = x.cnt;
        end else begin
            n      = x;
            n.hilo = '0;
            n.cnt  = '0;
        end
        return n;
    endfunction

    // Drive one cycle, push expectation, compare after the edge.
    task automatic cycle(input string tag);
        st_t e;
        model = next_state(model, in, rst, flush, stall);
        sb.push_back(model);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".wd"},    64'(dut.wd),    64'(e.wd));
            chk({tag, ".wreg"},  64'(dut.wreg),  64'(e.wreg));
            chk({tag, ".wdata"}, 64'(dut.wdata), 64'(e.wdata));
            chk({tag, ".hi"},    64'(dut.hi),    64'(e.hi));
            chk({tag, ".lo"},    64'(dut.lo),    64'(e.lo));
            chk({tag, ".whilo"}, 64'(dut.whilo), 64'(e.whilo));
            chk({tag, ".aluop"}, 64'(dut.aluop), 64'(e.aluop));
            chk({tag, ".addr"},  64'(dut.addr),  64'(e.addr));
            chk({tag, ".reg2"},  64'(dut.reg2),  64'(e.reg2));
            chk({tag, ".hilo"},  dut.hilo,       e.hilo);
            chk({tag, ".cnt"},   64'(dut.cnt),   64'(e.cnt));
        end
    endtask

    task automatic rand_in();
        in.wd    = 5'($urandom);
        in.wreg  = 1'($urandom);
        in.wdata = $urandom;
        in.hi    = $urandom;
        in.lo    = $urandom;
        in.whilo = 1'($urandom);
        in.aluop = 8'($urandom);
        in.addr  = $urandom;
        in.reg2  = $urandom;
        in.hilo  = {$urandom, $urandom};
        in.cnt   = 2'($urandom);
    endtask

    initial begin
        model = '0;
        // Reset with junk on every input, flush and stall also asserted.
        rst = 1'b1; flush = 1'b1; stall = 6'b111111;
        rand_in();
        cycle("reset");

        // Normal capture.
        rst = 1'b0; flush = 1'b0; stall = 6'b000000;
        rand_in();
        in.wd = 5'd3; in.wreg = 1'b1; in.wdata = 32'h1234_5678;
        in.hilo = 64'hDEAD_BEEF_0000_0001; in.cnt = 2'd3;
        cycle("normal");
        chk("normal.const_wdata", 64'(dut.wdata), 64'h1234_5678);
        chk("normal.const_cnt",   64'(dut.cnt),   64'd0);

        // Hold for three cycles while inputs keep changing.
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            cycle("hold");
            chk("hold.const_wdata", 64'(dut.wdata), 64'h1234_5678);
        end

        // Bubble: NOP forward, multi-cycle state looped back.
        stall = 6'b001111;
        rand_in();
        in.hilo = 64'h0000_0001_FFFF_FFFF; in.cnt = 2'd1;
        cycle("bubble");
        chk("bubble.const_hilo", dut.hilo,       64'h0000_0001_FFFF_FFFF);
        chk("bubble.const_cnt",  64'(dut.cnt),   64'd1);
        chk("bubble.const_wreg", 64'(dut.wreg),  64'd0);

        // Flush while EX stalled abandons the multi-cycle op.
        flush = 1'b1;
        rand_in();
        cycle("flush");
        chk("flush.const_cnt", 64'(dut.cnt), 64'd0);
        flush = 1'b0;

        // Flush while MEM stalled still clears.
        stall = 6'b000000; rand_in(); cycle("refill");
        stall = 6'b011000; flush = 1'b1; rand_in(); cycle("flush_hold");
        flush = 1'b0;

        // Reset mid-operation.
        stall = 6'b000000;
        rand_in(); in.whilo = 1'b1; in.hi = 32'hAAAA_AAAA;
        cycle("pre_rst");
        stall = 6'b001000; rand_in(); in.cnt = 2'd2; in.hilo = 64'h1111_2222_3333_4444;
        cycle("mid_op");
        rst = 1'b1; rand_in();
        cycle("rst_mid");
        chk("rst_mid.const_hi",    64'(dut.hi),    64'd0);
        chk("rst_mid.const_whilo", 64'(dut.whilo), 64'd0);
        chk("rst_mid.const_hilo",  dut.hilo,       64'd0);

        // First edge after reset obeys stall: bubble captures hilo_i.
        rst = 1'b0; stall = 6'b001000; rand_in();
        cycle("post_rst_bubble");

        // Illegal stall (MEM only) behaves as hold; ignored bits toggled.
        stall = 6'b000000; rand_in(); cycle("pre_illegal");
        stall = 6'b010000;
        for (int i = 0; i < 2; i++) begin rand_in(); cycle("illegal"); end
        stall = 6'b100111; rand_in(); cycle("ignored_bits");

        // Short random run.
        for (int i = 0; i < 60; i++) begin
            rand_in();
            stall = 6'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 19) == 0);
            cycle("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of the register data, HI/LO, address and store-data fields.
REQ-002 Parameter ADDR_W, default 5, width of the destination register address.
REQ-003 Parameter OP_W, default 8, width of the ALU/memory opcode field.
REQ-004 Parameter CNT_W, default 2, width of the multi-cycle step counter.
REQ-005 Ports: clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 Ports: rst  in  1  synchronous reset, active-high (asserted value is `RstEnable).
REQ-007 Ports: stall  in  6  pipeline stall vector; bit 3 is the EX stall, bit 4 is the MEM stall.
REQ-008 Ports: flush  in  1  exception flush; clears the stage.
REQ-009 Ports: ex_wd  in  ADDR_W, ex_wreg  in  1, ex_wdata  in  DATA_W  GPR writeback from EX.
REQ-010 Ports: ex_hi, ex_lo  in  DATA_W each, ex_whilo  in  1  HI/LO writeback from EX.
REQ-011 Ports: ex_aluop  in  OP_W, ex_mem_addr  in  DATA_W, ex_reg2  in  DATA_W  load/store information.
REQ-012 Ports: hilo_i  in  2*DATA_W, cnt_i  in  CNT_W  multi-cycle (madd/msub) intermediate result and step count from EX.
REQ-013 Ports: mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  registered copies of the matching ex_* inputs.
REQ-014 Ports: hilo_o  out  2*DATA_W, cnt_o  out  CNT_W  intermediate result and step count returned to EX.

Function
REQ-015 Every output SHALL be a register; there is no combinational path from input to output.
REQ-016 Mode priority on each edge SHALL be: rst, then flush, then stall, then normal.
REQ-017 Normal mode (stall[3]=0): all mem_* outputs SHALL take their ex_* values with 1-cycle latency, and hilo_o and cnt_o SHALL be cleared to zero.
REQ-018 Bubble mode (stall[3]=1, stall[4]=0): mem_* outputs SHALL be set to NOP (wd=`NOPRegAddr, wreg=0, wdata=0, hi=lo=0, whilo=0, aluop=`EXE_NOP_OP, addr=reg2=0), and hilo_o<=hilo_i and cnt_o<=cnt_i.
REQ-019 Hold mode (stall[3]=1, stall[4]=1): all outputs, including hilo_o and cnt_o, SHALL keep their values.
REQ-020 stall[3]=0 with stall[4]=1 is illegal; the block SHALL treat it as hold mode.
REQ-021 flush=1 SHALL clear all outputs to NOP/zero regardless of stall, so that a multi-cycle operation in progress is abandoned.
REQ-022 Stall bits other than 3 and 4 SHALL be ignored.
REQ-023 cnt_o SHALL NOT increment internally; it only captures cnt_i or is cleared.
REQ-024 With DATA_W=64, hilo_o SHALL be 128 bits, with no truncation of hilo_i.

Reset
REQ-025 When rst=1 at a rising edge, every output SHALL be zero or NOP on the following cycle, regardless of flush or stall.
REQ-026 Reset asserted in the middle of a multi-cycle sequence SHALL clear cnt_o and hilo_o in the same edge.
REQ-027 The first edge after rst deasserts SHALL operate in the mode selected by stall and flush.

Structure
REQ-028 `RstEnable, `NOPRegAddr, `ZeroWord, `EXE_NOP_OP, the stall bit indices (3 and 4), and the OP_W default SHALL live in the shared defines package.
REQ-029 The block SHALL be a single module with one clocked process; a sub-module named pipe_field_reg (a parametrised width register with clear and hold) is permitted, one instance per field group.

Verification
REQ-030 Normal mode: ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678, stall=0 -> one cycle later mem_wd=3, mem_wreg=1, mem_wdata=32'h1234_5678, hilo_o=0, cnt_o=0.
REQ-031 Bubble mode: stall=6'b001111, hilo_i=64'h0000_0001_FFFF_FFFF, cnt_i=1 -> mem_wreg=0, mem_wd=0, hilo_o=64'h0000_0001_FFFF_FFFF, cnt_o=1.
REQ-032 Hold mode: after REQ-030, apply stall=6'b011111 for 3 cycles while changing all ex_* inputs -> mem_wdata stays 32'h1234_5678 for all 3 cycles.
REQ-033 Flush with stall: stall=6'b001111, cnt_o=1, then flush=1 -> next cycle every output is 0 and cnt_o=0.
REQ-034 Reset mid-operation: rst=1 while the stage holds whilo=1, hi=32'hAAAA_AAAA -> next cycle mem_whilo=0, mem_hi=0, hilo_o=0.
REQ-035 Illegal stall: stall=6'b010000 -> all outputs hold their values, with no capture of ex_* inputs.
